// File: rtl/mem_if_pkg.sv
// Shared definitions for the Mem_Subsystem load/store initiator.
//   state_t     : initiator FSM states
//   ADDR_W_DEF  : default address width
//   DATA_W_DEF  : default data width
//   LOAD_OP     : req_write value selecting a load
//   STORE_OP    : req_write value selecting a store
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } state_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic LOAD_OP  = 1'b0;
  localparam logic STORE_OP = 1'b1;

endpackage

// File: rtl/mem_access_initiator_if.sv
// Bundle of the core-side request/response handshake and the Mem_Subsystem
// strobe interface.
//   master : the initiator (accepts requests, drives strobes and responses)
//   slave  : the environment (core + Mem_Subsystem) seen from outside
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_error                 : core response
//   input_address/LOAD/STORE/store_data              : to Mem_Subsystem
//   data/MEM_READY                                   : from Mem_Subsystem
interface mem_access_initiator_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  logic [ADDR_W-1:0] input_address;
  logic              LOAD;
  logic              STORE;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] data;
  logic              MEM_READY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, data, MEM_READY,
    output req_ready, resp_valid, resp_rdata, resp_error,
           input_address, LOAD, STORE, store_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, data, MEM_READY,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           input_address, LOAD, STORE, store_data
  );

endinterface

// File: rtl/mem_access_initiator.sv
// Core-side initiator for the Mem_Subsystem load/store interface.
// Accepts one request at a time, drives LOAD or STORE until MEM_READY or a
// timeout, returns a one-cycle response, then inserts a one-cycle idle gap.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-high reset
//   bus   : mem_access_initiator_if master modport (request, response and
//           Mem_Subsystem signals)
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mem_access_initiator_if.master bus
);

  state_t            state;
  state_t            next_state;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_error_q;
  logic [ADDR_W-1:0] input_address_q;
  logic [DATA_W-1:0] store_data_q;
  logic              load_q;
  logic              store_q;
  logic              write_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              done_ok;
  logic              timeout;

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_error    = resp_error_q;
  assign bus.input_address = input_address_q;
  assign bus.store_data    = store_data_q;
  assign bus.LOAD          = load_q;
  assign bus.STORE         = store_q;

  // cnt counts strobe cycles: 0 during ISSUE, 1 in the first WAIT cycle, so
  // expiring at TIMEOUT_CYCLES-1 yields exactly TIMEOUT_CYCLES strobe cycles.
  always_comb begin
    accept  = 1'b0;
    done_ok = 1'b0;
    timeout = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (bus.MEM_READY) begin
          done_ok    = 1'b1;
          next_state = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are registered from next_state so they change on the same edge
  // as the state and the reset can clear them asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_error_q    <= 1'b0;
      input_address_q <= '0;
      store_data_q    <= '0;
      load_q          <= 1'b0;
      store_q         <= 1'b0;
      write_q         <= LOAD_OP;
      cnt             <= '0;
    end else begin
      req_ready_q  <= (next_state == IDLE);
      resp_valid_q <= (next_state == RESP);

      if (accept) begin
        input_address_q <= bus.req_addr;
        store_data_q    <= bus.req_wdata;
        write_q         <= bus.req_write;
        load_q          <= (bus.req_write == LOAD_OP);
        store_q         <= (bus.req_write == STORE_OP);
      end

      if (done_ok || timeout) begin
        load_q       <= 1'b0;
        store_q      <= 1'b0;
        resp_error_q <= timeout;
        resp_rdata_q <= (done_ok && (write_q == LOAD_OP)) ? bus.data : '0;
      end

      if (state == IDLE) begin
        cnt <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Core-side initiator for the Mem_Subsystem load/store interface. It accepts one load or store request from the core over a valid/ready handshake and drives input_address, LOAD and STORE toward Mem_Subsystem.
- It waits for MEM_READY, captures read data, and returns a single-cycle response to the core.
- It enforces one outstanding access, a one-cycle idle gap between accesses, and a bounded wait with timeout error reporting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 32, maximum cycles to wait for MEM_READY before aborting (must be ≥ 2).
- CNT_W, 6, timeout counter width (must be ≥ clog2(TIMEOUT_CYCLES+1)).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  initiator can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid; 1 = timeout.
- input_address  out  ADDR_W  address to Mem_Subsystem.
- LOAD  out  1  load strobe to Mem_Subsystem.
- STORE  out  1  store strobe to Mem_Subsystem.
- store_data  out  DATA_W  write data to Mem_Subsystem.
- data  in  DATA_W  read data from Mem_Subsystem.
- MEM_READY  in  1  Mem_Subsystem completion; valid only while LOAD or STORE is high.

Behaviour:
- Reset values (asynchronous, while RESET=1):
  - state=IDLE, req_ready=0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - LOAD=0, STORE=0, input_address=0, store_data=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: register addr, write flag and wdata; go to ISSUE.
- ISSUE (1 cycle):
  - input_address and store_data are driven from the registered values.
  - Assert LOAD if write=0, STORE if write=1; never both.
  - Clear the counter; go to WAIT.
- WAIT:
  - Strobe and address are held stable; the counter increments each cycle.
  - On MEM_READY=1: deassert the strobe on the next edge, capture data into resp_rdata if it is a load, resp_error=0, go to RESP.
  - On counter == TIMEOUT_CYCLES-1 without MEM_READY: deassert the strobe, resp_rdata=0, resp_error=1, go to RESP.
  - MEM_READY and timeout in the same cycle: MEM_READY wins (success).
- RESP:
  - resp_valid=1 for exactly one cycle; go to GAP.
  - The response is not backpressured; the core must accept it.
- GAP (1 cycle):
  - All strobes are low, req_ready=0; go to IDLE.
  - This guarantees at least one low cycle between consecutive strobes.
- Latency:
  - Request accept to first strobe cycle: 1.
  - MEM_READY to resp_valid: 1 cycle.
  - Minimum request-to-request throughput: 5 cycles.
- Register stability:
  - resp_rdata and resp_error hold their values after resp_valid until the next response.
  - input_address holds its last value while idle.
- MEM_READY outside WAIT is ignored.
- req_valid while req_ready=0 is ignored; the core must hold the request.
- Reset mid-access: the strobe drops immediately (asynchronous) and no response is issued for the aborted access.
- No X on any output after reset.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encoding enum (IDLE, ISSUE, WAIT, RESP, GAP);
  - ADDR_W/DATA_W defaults;
  - the request-type constant (LOAD_OP=0, STORE_OP=1).
- Sub-module: none required.
- Optional: mem_timeout_counter (clear/enable/expire) if it is reused by the Mem_Subsystem bench.

Test Plan:
- Load: req addr 0x19 write=0. Memory model asserts MEM_READY 20 cycles after LOAD with data=0xDEADBEEF. Required:
  - LOAD high 20 cycles, STORE=0;
  - resp_valid one cycle, resp_rdata=0xDEADBEEF, resp_error=0.
- Store: addr 0x04, wdata=0x12345678, MEM_READY after 3 cycles. Required:
  - STORE high 3 cycles, store_data=0x12345678, LOAD=0;
  - resp_valid with resp_rdata=0, resp_error=0.
- Timeout: load addr 0x19 with MEM_READY never asserted. Required:
  - LOAD high exactly 32 cycles, then low;
  - resp_error=1, resp_rdata=0;
  - req_ready returns 2 cycles later.
- Back-to-back: loads 0x19, 0x04, 0x19 presented continuously with MEM_READY after 1 cycle. Required:
  - three responses in order;
  - at least one cycle with LOAD=0 between accesses;
  - req_ready=0 during each access.
- Simultaneous: MEM_READY arrives exactly on the timeout cycle → success response, resp_error=0, data captured.
- Reset: assert RESET while in WAIT with LOAD high. Required:
  - LOAD=0 in the same cycle, no resp_valid;
  - after release, req_ready=1 and the next load completes normally.
